// File: rtl/cam_power_seq.sv
// Camera bring-up sequencer: timed sensor power-up, SCCB configuration with
// timeout and bounded retries, then capture and stream enables.
module cam_power_seq #(
  parameter logic [23:0] PWDN_CYC   = 24'd500000,
  parameter logic [23:0] RST_CYC    = 24'd100000,
  parameter logic [23:0] BOOT_CYC   = 24'd2000000,
  parameter logic [23:0] CFG_TO     = 24'd8000000,
  parameter logic [23:0] STREAM_DLY = 24'd1000,
  parameter int          MAX_RETRY  = 2,
  parameter bit          FAST_SIM   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       cfg_done,
  input  logic       cfg_err,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       capture_en,
  output logic       stream_en,
  output logic       seq_done,
  output logic       seq_fail,
  output logic [2:0] retry_cnt
);

  localparam logic [23:0] PWDN_N   = FAST_SIM ? 24'd4 : PWDN_CYC;
  localparam logic [23:0] RST_N    = FAST_SIM ? 24'd4 : RST_CYC;
  localparam logic [23:0] BOOT_N   = FAST_SIM ? 24'd4 : BOOT_CYC;
  localparam logic [23:0] CFG_N    = FAST_SIM ? 24'd4 : CFG_TO;
  localparam logic [23:0] STREAM_N = FAST_SIM ? 24'd4 : STREAM_DLY;
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PWDN, S_RESET, S_BOOT, S_CFG_REQ, S_CFG_WAIT, S_ARM, S_RUN, S_FAIL
  } state_t;

  typedef struct packed {
    logic pwdn;
    logic rst_n;
    logic start;
    logic capture;
    logic stream;
    logic done;
    logic fail;
  } pins_t;

  state_t      state, nxt;
  logic [23:0] cnt;
  logic        go, timed, timeout;
  logic [3:0]  attempt;
  logic [2:0]  retry_nxt;
  pins_t       pins;

  // Output pins as seen in each state; registered alongside the state itself.
  function automatic pins_t decode(input state_t s);
    pins_t p;
    p = '0;
    case (s)
      S_PWDN:     p.pwdn = 1'b1;
      S_RESET:    p.pwdn = 1'b0;
      S_BOOT:     p.rst_n = 1'b1;
      S_CFG_REQ:  begin p.rst_n = 1'b1; p.start = 1'b1; end
      S_CFG_WAIT: p.rst_n = 1'b1;
      S_ARM:      begin p.rst_n = 1'b1; p.capture = 1'b1; end
      S_RUN:      begin p.rst_n = 1'b1; p.capture = 1'b1; p.stream = 1'b1; p.done = 1'b1; end
      S_FAIL:     begin p.pwdn = 1'b1; p.fail = 1'b1; end
    endcase
    return p;
  endfunction

  // The configuration window already spent one cycle in CFG_REQ.
  assign timeout = (CFG_N == 24'd1) || (cnt == CFG_N - 24'd2);
  assign attempt = {1'b0, retry_cnt} + 4'd1;
  assign timed   = state inside {S_PWDN, S_RESET, S_BOOT, S_CFG_WAIT, S_ARM};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    go        = 1'b0;
    nxt       = state;
    retry_nxt = retry_cnt;
    case (state)
      S_PWDN:    if (cnt == PWDN_N - 24'd1) begin go = 1'b1; nxt = S_RESET; end
      S_RESET:   if (cnt == RST_N - 24'd1)  begin go = 1'b1; nxt = S_BOOT; end
      S_BOOT:    if (cnt == BOOT_N - 24'd1) begin go = 1'b1; nxt = S_CFG_REQ; end
      S_CFG_REQ: begin go = 1'b1; nxt = S_CFG_WAIT; end
      S_CFG_WAIT: begin
        if (cfg_err || (!cfg_done && timeout)) begin
          go        = 1'b1;
          retry_nxt = (attempt > RETRY_MAX) ? retry_cnt : attempt[2:0];
          nxt       = (attempt < RETRY_MAX) ? S_PWDN : S_FAIL;
        end else if (cfg_done) begin
          go  = 1'b1;
          nxt = S_ARM;
        end
      end
      S_ARM:     if (cnt == STREAM_N - 24'd1) begin go = 1'b1; nxt = S_RUN; end
      S_RUN, S_FAIL: begin
        if (restart) begin
          go        = 1'b1;
          nxt       = S_PWDN;
          retry_nxt = 3'd0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PWDN;
      cnt       <= '0;
      retry_cnt <= '0;
      pins      <= decode(S_PWDN);
    end else begin
      retry_cnt <= retry_nxt;
      if (go) begin
        state <= nxt;
        cnt   <= '0;
        pins  <= decode(nxt);
      end else if (timed) begin
        cnt <= cnt + 24'd1;
      end
    end
  end

  assign cam_pwdn   = pins.pwdn;
  assign cam_rst_n  = pins.rst_n;
  assign cfg_start  = pins.start;
  assign capture_en = pins.capture;
  assign stream_en  = pins.stream;
  assign seq_done   = pins.done;
  assign seq_fail   = pins.fail;

endmodule

// File: tb/tb_cam_power_seq.sv
// Directed bench for cam_power_seq with FAST_SIM=1 (all dwells 4 cycles):
// per-cycle vector table plus an edge-timing measurement of the bring-up.
module tb_cam_power_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_err = 1'b0;
  logic       cam_pwdn, cam_rst_n, cfg_start, capture_en, stream_en, seq_done, seq_fail;
  logic [2:0] retry_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cam_power_seq #(.FAST_SIM(1'b1), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .restart(restart), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .cfg_start(cfg_start),
    .capture_en(capture_en), .stream_en(stream_en), .seq_done(seq_done),
    .seq_fail(seq_fail), .retry_cnt(retry_cnt)
  );

  // Inputs {rst, restart, cfg_done, cfg_err}
  localparam logic [3:0] I_IDLE = 4'b0000, I_ERR = 4'b0001, I_DONE = 4'b0010,
                         I_BOTH = 4'b0011, I_RESTART = 4'b0100, I_RST = 4'b1000;
  // Outputs {cam_pwdn, cam_rst_n, cfg_start, capture_en, stream_en, seq_done, seq_fail}
  localparam logic [6:0] O_PWDN = 7'b1000000, O_RESET = 7'b0000000, O_BOOT = 7'b0100000,
                         O_REQ  = 7'b0110000, O_WAIT  = 7'b0100000, O_ARM  = 7'b0101000,
                         O_RUN  = 7'b0101110, O_FAIL  = 7'b1000001;

  typedef struct packed {
    logic [3:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic [3:0] in, input logic [6:0] o, input logic [2:0] r);
    vec_t v;
    v.in  = in;
    v.exp = {o, r};
    repeat (n) vecs.push_back(v);
  endtask

  // Edges 1..13 after reset/restart/retry: PWDN tail, RESET, BOOT, CFG_REQ, first CFG_WAIT.
  task automatic bringup(input logic [2:0] r);
    add(3, I_IDLE, O_PWDN, r);
    add(4, I_IDLE, O_RESET, r);
    add(4, I_IDLE, O_BOOT, r);
    add(1, I_IDLE, O_REQ, r);
    add(1, I_IDLE, O_WAIT, r);
  endtask

  initial begin
    int pf, rr, se, sc, ce, te;

    // Nominal run with inputs that must be ignored in BOOT and RUN
    add(2, I_RST, O_PWDN, 3'd0);
    add(3, I_IDLE, O_PWDN, 3'd0);
    add(4, I_IDLE, O_RESET, 3'd0);
    add(1, I_IDLE, O_BOOT, 3'd0);
    add(1, I_DONE, O_BOOT, 3'd0);
    add(1, I_RESTART, O_BOOT, 3'd0);
    add(1, I_ERR, O_BOOT, 3'd0);
    add(1, I_IDLE, O_REQ, 3'd0);
    add(2, I_IDLE, O_WAIT, 3'd0);
    add(1, I_DONE, O_ARM, 3'd0);
    add(3, I_IDLE, O_ARM, 3'd0);
    add(1, I_IDLE, O_RUN, 3'd0);
    add(1, I_ERR, O_RUN, 3'd0);
    add(1, I_IDLE, O_RUN, 3'd0);
    add(1, I_RESTART, O_PWDN, 3'd0);
    // Error on attempt 1, success on attempt 2; retry_cnt survives success
    bringup(3'd0);
    add(1, I_ERR, O_PWDN, 3'd1);
    bringup(3'd1);
    add(1, I_IDLE, O_WAIT, 3'd1);
    add(1, I_DONE, O_ARM, 3'd1);
    add(3, I_IDLE, O_ARM, 3'd1);
    add(1, I_IDLE, O_RUN, 3'd1);
    add(1, I_RESTART, O_PWDN, 3'd0);
    // Two timeouts into FAIL, then restart out of FAIL
    bringup(3'd0);
    add(2, I_IDLE, O_WAIT, 3'd0);
    add(1, I_IDLE, O_PWDN, 3'd1);
    bringup(3'd1);
    add(2, I_IDLE, O_WAIT, 3'd1);
    add(1, I_IDLE, O_FAIL, 3'd2);
    add(1, I_DONE, O_FAIL, 3'd2);
    add(1, I_ERR, O_FAIL, 3'd2);
    add(1, I_RESTART, O_PWDN, 3'd0);
    // err+done together counts as error; rst mid-CFG_WAIT; done on the timeout cycle wins
    bringup(3'd0);
    add(1, I_BOTH, O_PWDN, 3'd1);
    bringup(3'd1);
    add(1, I_IDLE, O_WAIT, 3'd1);
    add(1, I_RST, O_PWDN, 3'd0);
    bringup(3'd0);
    add(2, I_IDLE, O_WAIT, 3'd0);
    add(1, I_DONE, O_ARM, 3'd0);
    add(3, I_IDLE, O_ARM, 3'd0);
    add(1, I_IDLE, O_RUN, 3'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      {rst, restart, cfg_done, cfg_err} = vecs[i].in;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {22'd0, cam_pwdn, cam_rst_n, cfg_start, capture_en, stream_en,
             seq_done, seq_fail, retry_cnt},
            {22'd0, vecs[i].exp});
    end

    // Edge-numbered timing of a fresh bring-up, cfg_done 2 cycles after cfg_start
    pf = 0; rr = 0; se = 0; sc = 0; ce = 0; te = 0;
    repeat (2) begin
      @(negedge clk);
      {rst, restart, cfg_done, cfg_err} = I_RST;
    end
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk);
      rst      = 1'b0;
      cfg_done = (se != 0) && (e == se + 3);
      @(posedge clk);
      #1;
      if (pf == 0 && !cam_pwdn) pf = e;
      if (rr == 0 && cam_rst_n) rr = e;
      if (cfg_start) begin
        sc++;
        if (se == 0) se = e;
      end
      if (ce == 0 && capture_en) ce = e;
      if (te == 0 && stream_en) te = e;
    end
    cfg_done = 1'b0;
    check("pwdn_fall_edge", pf, 4);
    check("rst_n_rise_edge", rr, 8);
    check("cfg_start_edge", se, 12);
    check("cfg_start_cycles", sc, 1);
    check("capture_rise_edge", ce, 15);
    check("stream_after_capture", te - ce, 4);
    check("seq_done_final", {31'd0, seq_done}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
